// File: rtl/renode_axi_pkg.sv
// Shared AXI burst/response types and burst address generation for the
// Renode memory bridge subordinates.
package renode_axi_pkg;

    typedef logic [7:0] burst_length_t;
    typedef logic [2:0] burst_size_t;
    typedef logic [1:0] burst_type_t;
    typedef logic [1:0] response_t;

    localparam burst_type_t BurstFixed = 2'd0;
    localparam burst_type_t BurstIncr  = 2'd1;
    localparam burst_type_t BurstWrap  = 2'd2;

    localparam response_t RespOkay   = 2'd0;
    localparam response_t RespSlvErr = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StResp = 2'd2
    } wr_state_e;

    function automatic logic wrap_len_ok(input burst_length_t len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Computed at 64 bits so read and write subordinates of any address width
    // up to 64 can share it; callers truncate to their own width.
    function automatic logic [63:0] next_burst_address(
        input logic [63:0]   addr,
        input burst_size_t   size,
        input burst_length_t len,
        input burst_type_t   burst
    );
        logic [63:0] step;
        logic [63:0] wrap_mask;
        logic [63:0] incr;
        logic [63:0] result;
        step      = 64'd1 << size;
        wrap_mask = ((64'(len) + 64'd1) << size) - 64'd1;
        incr      = addr + step;
        case (burst)
            BurstFixed: result = addr;
            BurstWrap:  result = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:    result = incr;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/renode_axi_write_subordinate.sv
// AXI4 write subordinate: splits each AW/W burst into single-beat memory
// write requests and returns one B response per burst.
module renode_axi_write_subordinate
    import renode_axi_pkg::*;
#(
    parameter int AddressWidth       = 64,
    parameter int DataWidth          = 64,
    parameter int TransactionIdWidth = 8
) (
    input  logic                          i_aclk,
    input  logic                          i_areset,
    input  logic [TransactionIdWidth-1:0] i_awid,
    input  logic [AddressWidth-1:0]       i_awaddr,
    input  burst_length_t                 i_awlen,
    input  burst_size_t                   i_awsize,
    input  burst_type_t                   i_awburst,
    input  logic                          i_awvalid,
    output logic                          o_awready,
    input  logic [DataWidth-1:0]          i_wdata,
    input  logic [DataWidth/8-1:0]        i_wstrb,
    input  logic                          i_wlast,
    input  logic                          i_wvalid,
    output logic                          o_wready,
    output logic [TransactionIdWidth-1:0] o_bid,
    output response_t                     o_bresp,
    output logic                          o_bvalid,
    input  logic                          i_bready,
    output logic                          o_mem_valid,
    input  logic                          i_mem_ready,
    output logic [AddressWidth-1:0]       o_mem_addr,
    output logic [DataWidth-1:0]          o_mem_wdata,
    output logic [DataWidth/8-1:0]        o_mem_strb,
    input  logic                          i_mem_err
);

    localparam burst_size_t MaxSize = burst_size_t'($clog2(DataWidth / 8));

    wr_state_e                     r_state;
    logic [TransactionIdWidth-1:0] r_id;
    logic [AddressWidth-1:0]       r_addr;
    burst_length_t                 r_len;
    burst_size_t                   r_size;
    burst_type_t                   r_burst;
    burst_length_t                 r_cnt;
    logic                          r_err;
    logic                          r_bad;

    logic                    w_in_data;
    logic                    w_bad_aw;
    logic                    w_beat;
    logic                    w_last;
    logic                    w_mem_fire;
    logic                    w_err_next;
    logic [AddressWidth-1:0] w_next_addr;

    assign w_bad_aw = (i_awsize > MaxSize) || (i_awburst == 2'd3) ||
                      ((i_awburst == BurstWrap) && !wrap_len_ok(i_awlen));

    // Bad bursts are drained with wready held high so the manager never stalls.
    assign w_in_data   = (r_state == StData);
    assign o_wready    = w_in_data && (r_bad || i_mem_ready);
    assign o_mem_valid = w_in_data && !r_bad && i_wvalid;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = i_wdata;
    assign o_mem_strb  = i_wstrb;

    assign w_beat      = i_wvalid && o_wready;
    assign w_last      = (r_cnt == r_len);
    assign w_mem_fire  = o_mem_valid && i_mem_ready;
    assign w_err_next  = r_err || (w_mem_fire && i_mem_err) || (i_wlast != w_last);
    assign w_next_addr = AddressWidth'(next_burst_address(64'(r_addr), r_size, r_len, r_burst));

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state   <= StIdle;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= BurstFixed;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_bad     <= 1'b0;
            o_awready <= 1'b1;
            o_bvalid  <= 1'b0;
            o_bresp   <= RespOkay;
            o_bid     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_awvalid) begin
                        r_id      <= i_awid;
                        r_addr    <= i_awaddr;
                        r_len     <= i_awlen;
                        r_size    <= i_awsize;
                        r_burst   <= i_awburst;
                        r_cnt     <= '0;
                        r_err     <= w_bad_aw;
                        r_bad     <= w_bad_aw;
                        o_awready <= 1'b0;
                        r_state   <= StData;
                    end
                end
                StData: begin
                    if (w_beat) begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_err  <= w_err_next;
                        r_addr <= w_next_addr;
                        if (w_last) begin
                            o_bvalid <= 1'b1;
                            o_bid    <= r_id;
                            o_bresp  <= w_err_next ? RespSlvErr : RespOkay;
                            r_state  <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (i_bready) begin
                        o_bvalid  <= 1'b0;
                        o_awready <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    o_awready <= 1'b1;
                    o_bvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_renode_axi_write_subordinate.sv
// Randomized scoreboard bench for renode_axi_write_subordinate; expected beats
// and responses are computed from burst arithmetic and checked by monitors.
module tb_renode_axi_write_subordinate;
    import renode_axi_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 8;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic          mem_valid;
    logic          mem_ready = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_strb;
    logic          mem_err = 1'b0;

    always #5 clk = ~clk;

    renode_axi_write_subordinate #(
        .AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW)
    ) dut (
        .i_aclk(clk), .i_areset(areset),
        .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
        .i_awburst(awburst), .i_awvalid(awvalid), .o_awready(awready),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid),
        .o_wready(wready),
        .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_strb(mem_strb), .i_mem_err(mem_err)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } mem_exp_t;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    mem_exp_t mq[$];
    b_exp_t   bq[$];

    int n_tests = 0;
    int n_fail = 0;
    int rdy_mode = 0;
    int cyc = 0;
    int bv_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake at %0t", name, $time);
    endtask

    // Address of beat i from first principles: no stepping state carried over.
    function automatic logic [63:0] ref_addr(input logic [63:0] start, input int size,
                                             input int len, input int burst, input int i);
        logic [63:0] step;
        logic [63:0] wrap;
        logic [63:0] base;
        step = 64'd1 << size;
        if (burst == 0) return start;
        if (burst == 2) begin
            wrap = 64'(len + 1) * step;
            base = start - (start % wrap);
            return base + ((start - base + 64'(i) * step) % wrap);
        end
        return start + 64'(i) * step;
    endfunction

    // Ready generators: 0 = always ready, 1 = random, 2 = mem_ready 1,0,0,1 and
    // bready held low for the first five cycles of each response.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0: begin mem_ready = 1'b1; bready = 1'b1; end
                1: begin
                    mem_ready = ($urandom_range(0, 3) != 0);
                    bready    = ($urandom_range(0, 1) == 1);
                end
                default: begin
                    mem_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    bready    = (bv_cycles >= 5);
                end
            endcase
        end
    end

    // Monitors: compare DUT outputs against the scoreboard queues.
    initial begin
        bit          b_hold = 1'b0;
        bit          b_prev_done = 1'b0;
        logic [7:0]  hold_id = '0;
        logic [1:0]  hold_resp = '0;
        mem_exp_t    me;
        b_exp_t      be;
        forever begin
            @(negedge clk);
            if (areset) begin
                b_hold = 1'b0;
                b_prev_done = 1'b0;
                bv_cycles = 0;
            end else begin
                if (b_prev_done) chk("awready_after_b", 64'(awready), 64'd1);
                b_prev_done = 1'b0;
                if (mem_valid) chk("awready_low_in_data", 64'(awready), 64'd0);
                if (mem_valid && mem_ready) begin
                    chk("wready_with_mem_ready", 64'(wready), 64'd1);
                    if (mq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL mem_unexpected: got addr 0x%0h, expected no request", mem_addr);
                    end else begin
                        me = mq.pop_front();
                        chk("mem_addr", mem_addr, me.addr);
                        chk("mem_wdata", mem_wdata, me.data);
                        chk("mem_strb", 64'(mem_strb), 64'(me.strb));
                    end
                end
                if (bvalid) begin
                    chk("awready_low_in_resp", 64'(awready), 64'd0);
                    if (b_hold) begin
                        chk("bid_stable", 64'(bid), 64'(hold_id));
                        chk("bresp_stable", 64'(bresp), 64'(hold_resp));
                    end
                    if (bready) begin
                        if (bq.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL b_unexpected: got bid 0x%0h, expected no response", bid);
                        end else begin
                            be = bq.pop_front();
                            chk("bid", 64'(bid), 64'(be.id));
                            chk("bresp", 64'(bresp), 64'(be.resp));
                        end
                        b_prev_done = 1'b1;
                        b_hold = 1'b0;
                        bv_cycles = 0;
                    end else begin
                        b_hold = 1'b1;
                        hold_id = bid;
                        hold_resp = bresp;
                        bv_cycles++;
                    end
                end
            end
        end
    end

    task automatic send_burst(input logic [7:0] id, input logic [63:0] addr, input int len,
                              input int size, input int burst, input int wlast_bad,
                              input int err_beat, input int n_send, input bit gaps,
                              input logic [7:0] strb_fix);
        bit          bad;
        bit          err;
        int          t;
        logic [63:0] data[$];
        logic [7:0]  strb[$];
        mem_exp_t    me;
        b_exp_t      be;
        bad = (size > 3) || (burst == 3) ||
              ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
        err = bad || (wlast_bad >= 0 && wlast_bad <= len) || (err_beat >= 0 && err_beat <= len);
        for (int i = 0; i <= len; i++) begin
            data.push_back({$urandom, $urandom});
            strb.push_back(strb_fix != 8'd0 ? strb_fix : 8'($urandom));
        end
        if (!bad) begin
            for (int i = 0; i < n_send; i++) begin
                me.addr = ref_addr(addr, size, len, burst, i);
                me.data = data[i];
                me.strb = strb[i];
                mq.push_back(me);
            end
        end
        if (n_send == len + 1) begin
            be.id = id;
            be.resp = err ? 2'd2 : 2'd0;
            bq.push_back(be);
        end

        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (awready) break;
            if (++t > 200) begin
                timeout_fail("aw_handshake");
                awvalid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;

        for (int i = 0; i < n_send; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            wvalid  = 1'b1;
            wdata   = data[i];
            wstrb   = strb[i];
            wlast   = (i == len) ^ (i == wlast_bad);
            mem_err = (i == err_beat);
            t = 0;
            forever begin
                @(negedge clk);
                if (wready) break;
                if (++t > 200) begin
                    timeout_fail("w_handshake");
                    wvalid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            wvalid = 1'b0;
            wlast = 1'b0;
            mem_err = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((mq.size() != 0 || bq.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("mem_queue_drained", 64'(mq.size()), 64'd0);
        chk("b_queue_drained", 64'(bq.size()), 64'd0);
    endtask

    initial begin
        int len;
        int burst;
        int size;
        int wrap_lens[4] = '{1, 3, 7, 15};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_bid", 64'(bid), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Directed cases.
        rdy_mode = 0;
        send_burst(8'h5A, 64'h1000, 3, 3, 1, -1, -1, 4, 1'b0, 8'h00);
        send_burst(8'h11, 64'h1018, 3, 3, 2, -1, -1, 4, 1'b0, 8'h00);
        send_burst(8'h22, 64'h20, 1, 2, 0, -1, -1, 2, 1'b0, 8'h0F);
        send_burst(8'h33, 64'h40, 0, 4, 1, -1, -1, 1, 1'b0, 8'h00);
        send_burst(8'h44, 64'h80, 2, 3, 1, 1, -1, 3, 1'b0, 8'h00);
        send_burst(8'h55, 64'h100, 1, 3, 1, -1, 0, 2, 1'b0, 8'h00);
        send_burst(8'h66, 64'h200, 2, 2, 2, -1, -1, 3, 1'b0, 8'h00);
        wait_drain();

        rdy_mode = 2;
        send_burst(8'h77, 64'h3000, 3, 3, 1, -1, -1, 4, 1'b0, 8'h00);
        wait_drain();

        rdy_mode = 0;
        send_burst(8'h88, 64'h4000, 7, 3, 1, -1, -1, 2, 1'b0, 8'h00);
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("post_reset_awready", 64'(awready), 64'd1);
        chk("post_reset_bvalid", 64'(bvalid), 64'd0);
        chk("post_reset_wready", 64'(wready), 64'd0);
        @(posedge clk);
        #1;
        send_burst(8'h99, 64'h5000, 0, 3, 1, -1, -1, 1, 1'b0, 8'h00);
        wait_drain();

        // Randomized bursts with random handshakes.
        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            burst = int'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            size  = int'($urandom_range(0, 9) == 0 ? 4 : $urandom_range(0, 3));
            len   = int'($urandom_range(0, 15));
            if (burst == 2 && $urandom_range(0, 4) != 0) len = wrap_lens[$urandom_range(0, 3)];
            send_burst(8'($urandom), {$urandom, $urandom}, len, size, burst,
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1,
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1,
                       len + 1, 1'b1, 8'h00);
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/renode_axi_write_subordinate.md
Name: renode_axi_write_subordinate

Overview:
- AXI4 write-channel subordinate that sits directly downstream of the Renode AXI interface signals (AW/W/B).
- Converts each AXI write burst into a sequence of single-beat memory write requests on a valid/ready port.
- Returns one B response per burst.
- Used by the Renode memory bridge so bus managers in the DUT can write into Renode-backed memory.

Parameters:
- AddressWidth, 64, width of awaddr and mem_addr.
- DataWidth, 64, width of wdata and mem_wdata; must be 8, 16, 32 or 64.
- TransactionIdWidth, 8, width of awid and bid.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset; synchronous, active-high.
- awid  in  TransactionIdWidth  write address ID.
- awaddr  in  AddressWidth  burst start address.
- awlen  in  8  beats minus 1 (burst_length_t).
- awsize  in  3  log2 bytes per beat (burst_size_t).
- awburst  in  2  burst type: FIXED=0, INCR=1, WRAP=2 (burst_type_t).
- awvalid / awready  in / out  1  AW handshake.
- wdata  in  DataWidth  write data.
- wstrb  in  DataWidth/8  byte strobes.
- wlast  in  1  last beat marker.
- wvalid / wready  in / out  1  W handshake.
- bid  out  TransactionIdWidth  response ID.
- bresp  out  2  response: OKAY=0, SLVERR=2 (response_t).
- bvalid / bready  out / in  1  B handshake.
- mem_valid / mem_ready  out / in  1  memory write request handshake.
- mem_addr  out  AddressWidth  beat address.
- mem_wdata  out  DataWidth  beat data.
- mem_strb  out  DataWidth/8  beat strobes.
- mem_err  in  1  error flag, sampled when mem_valid && mem_ready.

Behaviour:
- FSM states: IDLE, DATA, RESP. Reset enters IDLE.
- Output reset values: awready=1, wready=0, bvalid=0, bresp=0, bid=0, mem_valid=0.
- IDLE: awready=1. On awvalid, capture id, addr, len, size and burst into registers; clear beat counter and error flag; go to DATA. W beats are never accepted in IDLE.
- DATA: awready=0.
  - Normal beats: mem_valid=wvalid; wready=mem_ready; mem_addr = current beat address; mem_wdata/mem_strb = wdata/wstrb, combinational pass-through. Zero added latency per beat.
  - Bad burst (unsupported_size || burst==3): wready=1, mem_valid=0. Beats are drained without memory writes; error flag is set at AW capture.
  - A beat completes on wvalid && wready. On completion: beat counter increments, error flag |= mem_err, address advances.
- Address advance rules (step = 1<<size):
  - FIXED: address unchanged.
  - INCR: addr + step, full AddressWidth arithmetic, no 4 KiB check.
  - WRAP: wrap_bytes = (len+1)<<size; base = start & ~(wrap_bytes-1); next = base | ((addr+step) & (wrap_bytes-1)). WRAP with len not in {1,3,7,15} is a bad burst.
- unsupported_size: (1<<awsize) > DataWidth/8.
- Burst ends on the beat where counter == len.
  - If wlast differs from (counter == len) on any completed beat, set the error flag.
  - Extra beats after the end are not accepted (wready=0 outside DATA).
- RESP: bvalid=1, bid=captured id, bresp = error flag ? SLVERR : OKAY.
  - bvalid and bresp stay stable until bready.
  - On bvalid && bready go to IDLE; awready rises the next cycle. Minimum burst-to-burst gap is 1 cycle.
- areset mid-burst: state returns to IDLE next cycle; outstanding beats are discarded and no B response is issued.
- mem_ready held low stalls W indefinitely. mem_valid, once asserted, follows wvalid; the AXI rule that a manager must keep wvalid asserted guarantees request stability.

Decomposition:
- burst_length_t, burst_size_t, burst_type_t, response_t and the burst/response encodings come from renode_axi_pkg. Add constants BurstFixed, BurstIncr, BurstWrap, RespOkay and RespSlvErr there.
- Add renode_axi_pkg function next_burst_address(addr, size, len, burst) for reuse by a future read subordinate.
- No sub-module. Address generation is the package function; the FSM is inline.

Test Plan:
- INCR, awaddr=0x1000, awlen=3, awsize=3, mem_ready=1 -> mem_addr 0x1000/0x1008/0x1010/0x1018 on consecutive cycles, then bvalid with bresp=0 and bid=awid.
- WRAP, awaddr=0x1018, awlen=3, awsize=3 -> mem_addr 0x1018/0x1000/0x1008/0x1010, bresp=0.
- FIXED, awaddr=0x20, awlen=1, awsize=2, wstrb=0x0F -> both beats at 0x20 with mem_strb=0x0F; then with DataWidth=32, awsize=3 -> no mem_valid, 1 beat drained, bresp=2.
- INCR, awlen=2 with wlast on beat 1 -> 3 beats accepted, bresp=2. Separately, mem_err=1 on beat 0 -> bresp=2.
- mem_ready toggling 1,0,0,1 and bready held low 5 cycles -> no beat lost, bvalid/bid/bresp stable until bready, awready=0 until the cycle after B completes.
- areset for 1 cycle after the 2nd beat of an awlen=7 burst -> IDLE with awready=1, bvalid=0; a following awlen=0 burst gets bresp=0.
